// File: rtl/piso_frame_serializer_pkg.sv
// Shared types and line levels for the framed PISO serializer.
//   state_e     : frame FSM states (PARITY is reachable only when PISO_PARITY_EN is defined)
//   *_LEVEL     : serial line levels for idle, start and stop bits
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/piso_frame_serializer_if.sv
// Load handshake plus serial output bundle of the framed serializer.
//   data_in/load_valid   : upstream word and its valid (master drives)
//   load_ready           : serializer can accept a word this cycle
//   data_out             : registered serial line, idles high
//   frame_active / done  : frame in progress / stop-bit pulse
// master = upstream producer / observer, slave = serializer.
interface piso_frame_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             data_out;
  logic             frame_active;
  logic             done;

  modport master (
    output data_in, load_valid,
    input  load_ready, data_out, frame_active, done
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, data_out, frame_active, done
  );
endinterface

// File: rtl/piso_frame_serializer_shift_word.sv
// Loadable WIDTH-bit shift register feeding the serial line.
//   clk, reset   : clock, synchronous active-high reset
//   load_i       : capture data_i (wins over shift_i)
//   data_i       : parallel word
//   shift_i      : advance to the next serial bit
//   bit_o        : current head bit (bit 0 when LSB_FIRST, else bit WIDTH-1)
//   parity_o     : even parity (XOR) of the word captured at the last load
module piso_shift_word #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             bit_o,
  output logic             parity_o
);

  logic [WIDTH-1:0] sreg_q, sreg_d, shifted;
  logic             par_q, par_d;

  // Parity is latched at load because the word is consumed as it shifts.
  generate
    if (LSB_FIRST) begin : g_lsb
      assign shifted = {1'b0, sreg_q[WIDTH-1:1]};
      assign bit_o   = sreg_q[0];
    end else begin : g_msb
      assign shifted = {sreg_q[WIDTH-2:0], 1'b0};
      assign bit_o   = sreg_q[WIDTH-1];
    end
  endgenerate

  always_comb begin
    sreg_d = sreg_q;
    par_d  = par_q;
    if (load_i) begin
      sreg_d = data_i;
      par_d  = ^data_i;
    end else if (shift_i) begin
      sreg_d = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q <= '0;
      par_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      par_q  <= par_d;
    end
  end

  assign parity_o = par_q;

endmodule

// File: rtl/piso_frame_serializer.sv
// Framed parallel-in / serial-out serializer: start(0), WIDTH data bits,
// optional even-parity bit, stop(1); line idles high.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of piso_frame_serializer_if (load handshake, serial out)
// Build option: define PISO_PARITY_EN to insert a PARITY bit between DATA and STOP.
// data_out is a flop loaded with the level of the state being entered, so the
// start bit appears in the cycle right after the handshake edge.
module piso_frame_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  piso_frame_serializer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             ready, xfer, shift_en, ser_bit, parity;

  assign ready    = (state_q == IDLE) || (state_q == STOP);
  assign xfer     = bus.load_valid && ready;
  // A bit is consumed from the word on every edge that enters or stays in DATA.
  assign shift_en = (state_d == DATA);

  piso_shift_word #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_word (
    .clk      (clk),
    .reset    (reset),
    .load_i   (xfer),
    .data_i   (bus.data_in),
    .shift_i  (shift_en),
    .bit_o    (ser_bit),
    .parity_o (parity)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = IDLE_LEVEL;
    unique case (state_q)
      IDLE:   if (xfer) state_d = START;
      START:  state_d = DATA;
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = xfer ? START : IDLE;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   dout_d = START_LEVEL;
      DATA:    dout_d = ser_bit;
      PARITY:  dout_d = parity;
      STOP:    dout_d = STOP_LEVEL;
      default: dout_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.load_ready   = ready;
  assign bus.data_out     = dout_q;
  assign bus.frame_active = (state_q != IDLE);
  assign bus.done         = (state_q == STOP);

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Scoreboard bench: two serializers (LSB-first and MSB-first) share one
// stimulus stream; each accepted word pushes its expected frame, and a
// monitor pops one expected bit per cycle and compares the line state.
module tb_piso_frame_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  bit         mon_en = 1'b0;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    bit da;    // expected bit, LSB-first instance
    bit db;    // expected bit, MSB-first instance
    bit done;  // stop bit
  } fexp_t;

  fexp_t q[$];

  always #5 clk = ~clk;

  piso_frame_serializer_if #(.WIDTH(8)) bus_a ();
  piso_frame_serializer_if #(.WIDTH(8)) bus_b ();

  assign bus_a.data_in    = data_in;
  assign bus_a.load_valid = load_valid;
  assign bus_b.data_in    = data_in;
  assign bus_b.load_valid = load_valid;

  piso_frame_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  piso_frame_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got{dout,done,act,rdy}=%b exp=%b", nm, $time, got, exp);
    end
  endtask

  // Frame built straight from the framing rules.
  task automatic push_frame(input logic [7:0] d);
    fexp_t e;
    e.done = 1'b0; e.da = 1'b0; e.db = 1'b0;
    q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.da = d[i];
      e.db = d[7-i];
      q.push_back(e);
    end
`ifdef PISO_PARITY_EN
    e.da = ^d; e.db = ^d;
    q.push_back(e);
`endif
    e.da = 1'b1; e.db = 1'b1; e.done = 1'b1;
    q.push_back(e);
  endtask

  // Monitor: one comparison per instance per cycle.
  initial begin
    fexp_t e;
    logic [3:0] ea, eb;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (q.size() > 0) begin
          e  = q.pop_front();
          ea = {e.da, e.done, 1'b1, e.done};
          eb = {e.db, e.done, 1'b1, e.done};
        end else begin
          ea = 4'b1001;
          eb = 4'b1001;
        end
        chk("lsb_line", {bus_a.data_out, bus_a.done, bus_a.frame_active, bus_a.load_ready}, ea);
        chk("msb_line", {bus_b.data_out, bus_b.done, bus_b.frame_active, bus_b.load_ready}, eb);
      end
    end
  end

  // Drive inputs for the next rising edge. An empty queue here means the
  // displayed cycle is idle or a stop bit, i.e. the block is ready.
  task automatic step(input bit v, input logic [7:0] d, input bit r, output bit acc);
    @(negedge clk);
    #1;
    load_valid = v;
    data_in    = d;
    reset      = r;
    acc        = 1'b0;
    if (r) q.delete();
    else if (v && q.size() == 0) begin
      push_frame(d);
      acc = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, acc);
  endtask

  task automatic send(input logic [7:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      step(1'b1, d, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout data=%h not accepted within 40 cycles", d);
    end
  endtask

  initial begin
    bit acc;
    // reset state
    @(posedge clk);
    #1 mon_en = 1'b1;
    step(1'b0, 8'h00, 1'b1, acc);
    idle(2);

    // single frames, both bit orders
    send(8'hA5); idle(12);
    send(8'hC0); idle(12);

    // back-to-back with valid held: second word taken in the stop cycle
    send(8'h3C); send(8'hFF); idle(12);

    // busy ignore: 00 presented throughout the A5 frame
    send(8'hA5); send(8'h00); idle(12);

    // reset during 4th data bit, with load_valid also high (word dropped)
    send(8'hA5);
    idle(4);
    step(1'b1, 8'hFF, 1'b1, acc);
    idle(2);
    send(8'h01); idle(12);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      bit r, v;
      logic [7:0] d;
      r = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 2) != 0);
      d = 8'($urandom);
      step(v, d, r, acc);
    end
    idle(15);
    chk("drain", {3'b000, q.size() == 0}, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_frame_serializer.md
Name: piso_frame_serializer

Overview:
- Upstream stage of the serial shift chain.
- Accepts a parallel word over a valid/ready handshake.
- Emits the word as a framed serial bit stream, one bit per clk: start bit (0), WIDTH data bits, stop bit (1).
- data_out drives the serial data input of the downstream shift-register stage. The line idles high between frames.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- LSB_FIRST, 1, 1 = transmit bit 0 first; 0 = transmit bit WIDTH-1 first.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word; sampled only on handshake.
- load_valid  input  1  upstream presents data_in.
- load_ready  output  1  block can accept a word this cycle.
- data_out  output  1  serial bit stream, registered.
- frame_active  output  1  high while a start, data, parity or stop bit is on data_out.
- done  output  1  one-cycle pulse coincident with the stop bit.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. On reset: data_out=1, load_ready=1, frame_active=0, done=0, state=IDLE, bit counter=0, shift register=0.
- Handshake: a transfer occurs at a rising edge where load_valid && load_ready. data_in is captured into the internal shift register at that edge.
- load_ready is high in IDLE and STOP only. It is low in START, DATA and PARITY. load_valid while load_ready=0 is ignored and does not affect data_out.
- Latency: transfer at edge k -> start bit on data_out during cycle k..k+1. First data bit follows at k+1..k+2.
- State machine:
  - IDLE: data_out=1. On transfer -> START.
  - START: data_out=0 for 1 cycle -> DATA.
  - DATA: WIDTH cycles, one bit per cycle, order per LSB_FIRST. Counter runs 0..WIDTH-1. At count WIDTH-1 -> STOP (or PARITY if enabled).
  - STOP: data_out=1, done=1 for 1 cycle. If a transfer occurs in this cycle -> START; else -> IDLE.
- Frame length: WIDTH+2 cycles. Back-to-back frames have no idle gap.
- frame_active=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- All outputs are registered; no combinational path from inputs to outputs. load_ready is a decode of registered state.
- Counter width is $clog2(WIDTH). The counter wraps to 0 on leaving DATA.
- Reset mid-frame: the frame is aborted. Next cycle data_out=1, load_ready=1, done=0. No partial stop bit and no done pulse.
- Reset asserted together with load_valid: reset wins and the word is dropped.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. data_out = even parity (XOR of all WIDTH captured bits) for 1 cycle. Frame length becomes WIDTH+3. load_ready stays low in PARITY.
- Undefined: no PARITY state; DATA goes directly to STOP.

Decomposition:
- Shared package piso_pkg:
  - state typedef (IDLE, START, DATA, PARITY, STOP).
  - constants: IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
- One natural sub-module: piso_shift_word. It holds the WIDTH-bit loadable shift register with direction per LSB_FIRST and exposes the current serial bit and the parity of the loaded word. The top level contains the FSM, counter and handshake.

Test Plan:
- WIDTH=8, LSB_FIRST=1: load 8'hA5 -> data_out = 0,1,0,1,0,0,1,0,1,1, then idle 1. done high only on the 10th bit. load_ready low for cycles 1-9.
- LSB_FIRST=0: load 8'hC0 -> data_out = 0,1,1,0,0,0,0,0,0,1.
- Back-to-back: 8'h3C then 8'hFF with load_valid held high -> second handshake occurs in the STOP cycle. 20 contiguous framed bits, no idle-high gap, two done pulses 10 cycles apart.
- Busy ignore: assert load_valid with 8'h00 during DATA of an 8'hA5 frame -> A5 frame unchanged, 8'h00 accepted only at the STOP cycle.
- Reset after 4th data bit of 8'hA5 -> next cycle data_out=1, load_ready=1, frame_active=0, no done pulse. A new load of 8'h01 then frames normally.
- PISO_PARITY_EN defined: load 8'hA5 (four ones) -> data_out = 0,1,0,1,0,0,1,0,1,0,1 (parity 0). Load 8'h01 -> parity bit 1.
